muldiv_unit: RTL

- Iterative 64-bit multiply/divide unit implementing the RISC-V M-extension operations for the single-cycle datapath's execute stage.
- Sits directly downstream of the register file: consumes `reg_data1` and `reg_data2` as operands.
- Its result goes back to the register file as `wr_data` through the writeback mux.
- A start/busy/done handshake lets control stall the PC while an operation is in flight.

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, with a one-cycle path for div-by-zero/overflow.
module muldiv_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic             r_neg;
  logic             r_rem_neg;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;

  logic             w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic             w_div_zero, w_ovf;
  logic [WIDTH-1:0] w_fast_result;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_hi_next, w_lo_next;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0] w_quo, w_rem;
  logic [WIDTH-1:0] w_calc_result;

  // Operand sign handling: MUL is taken unsigned since its low half is sign-agnostic.
  always_comb begin
    w_a_signed = op[2] ? ~op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
    w_b_signed = op[2] ? ~op[0] : (op[1:0] == 2'b01);
    w_a_neg    = w_a_signed & rs1_data[WIDTH-1];
    w_b_neg    = w_b_signed & rs2_data[WIDTH-1];
    w_a_mag    = w_a_neg ? -rs1_data : rs1_data;
    w_b_mag    = w_b_neg ? -rs2_data : rs2_data;
    w_div_zero = op[2] && (rs2_data == '0);
    w_ovf      = op[2] && !op[0] && (rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_data == '1);
    if (w_div_zero)
      w_fast_result = op[1] ? rs1_data : '1;
    else
      w_fast_result = op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  // One iteration: r_lo holds multiplier / dividend bits, r_hi the partial product / remainder.
  always_comb begin
    w_sum       = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_rem_shift = {r_hi, r_lo[WIDTH-1]};
    w_ge        = (w_rem_shift >= {1'b0, r_b});
    if (!r_op[2]) begin
      w_hi_next = w_sum[WIDTH:1];
      w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
    end else if (w_ge) begin
      w_hi_next = WIDTH'(w_rem_shift - {1'b0, r_b});
      w_lo_next = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_next = w_rem_shift[WIDTH-1:0];
      w_lo_next = {r_lo[WIDTH-2:0], 1'b0};
    end
    w_prod   = {w_hi_next, w_lo_next};
    w_prod_s = r_neg ? -w_prod : w_prod;
    w_quo    = r_neg ? -w_lo_next : w_lo_next;
    w_rem    = r_rem_neg ? -w_hi_next : w_hi_next;
    case (r_op)
      3'b000:                 w_calc_result = w_prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_calc_result = w_prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_calc_result = w_quo;
      default:                w_calc_result = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op      <= op;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_rem_neg <= w_a_neg;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= w_a_mag;
            r_b       <= w_b_mag;
            if (w_div_zero || w_ovf) begin
              r_result <= w_fast_result;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_result <= w_calc_result;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
